pe3_pair_feeder: RTL and testbench

Streaming pairing stage that sits directly upstream of the constant-twiddle butterfly PE. It accepts one 12-bit coefficient per cycle in natural order. In blocks of `2*stride` coefficients it buffers the first half, then emits butterfly operand pairs (u = first-half coefficient, v = matching second-half coefficient) on the butterfly's `u`/`v` inputs. It also carries a latency-matched valid so the butterfly's `bf_upper`/`bf_lower` outputs can be qualified downstream.

---
 rtl/pe3_pair_feeder_pkg.sv | 11 +
 rtl/pe3_pair_feeder_if.sv | 27 ++
 rtl/valid_delay.sv | 32 +++
 rtl/pe3_pair_feeder.sv | 106 ++++++++++
 tb/tb_pe3_pair_feeder.sv | 205 ++++++++++++++++++++
 5 files changed

// File: rtl/pe3_pair_feeder_pkg.sv
// Shared NTT constants and the coefficient type used by the pairing stage and its interface.
package pe3_pair_feeder_pkg;

  localparam int unsigned Q          = 3329;
  localparam int unsigned DATA_WIDTH = 12;
  localparam int unsigned PE3_LAT    = 6;
  localparam int unsigned STRIDE     = 8;

  typedef logic [DATA_WIDTH-1:0] coeff_t;

endpackage

// File: rtl/pe3_pair_feeder_if.sv
// Coefficient stream in, butterfly operand pairs and qualifiers out.
interface pe3_pair_feeder_if
  import pe3_pair_feeder_pkg::*;
#(
  parameter int unsigned DataWidth = DATA_WIDTH
) ();

  logic                 in_valid;
  logic [DataWidth-1:0] in_data;
  logic [DataWidth-1:0] u;
  logic [DataWidth-1:0] v;
  logic                 pair_valid;
  logic                 res_valid;
  logic                 blk_done;
  logic                 range_err;

  modport master (
    output in_valid, in_data,
    input  u, v, pair_valid, res_valid, blk_done, range_err
  );

  modport slave (
    input  in_valid, in_data,
    output u, v, pair_valid, res_valid, blk_done, range_err
  );

endinterface

// File: rtl/valid_delay.sv
// Fixed-depth 1-bit delay line with async active-low reset and synchronous clear.
module valid_delay #(
  parameter int unsigned Depth = 6
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clr_i,
  input  logic d_i,
  output logic q_o
);

  logic [Depth-1:0] sr_q, sr_d;

  // Shift-and-or form stays legal for Depth == 1.
  always_comb begin
    sr_d = (sr_q << 1) | Depth'(d_i);
    if (clr_i) begin
      sr_d = '0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sr_q <= '0;
    end else begin
      sr_q <= sr_d;
    end
  end

  assign q_o = sr_q[Depth-1];

endmodule

// File: rtl/pe3_pair_feeder.sv
// Buffers the first half of each 2*Stride block and pairs it with the second half for the
// butterfly, with latency-matched result/block qualifiers.
module pe3_pair_feeder
  import pe3_pair_feeder_pkg::*;
#(
  parameter int unsigned DataWidth = DATA_WIDTH,
  parameter int unsigned Stride    = STRIDE,
  parameter int unsigned PeLat     = PE3_LAT,
  parameter int unsigned Modulus   = Q
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             clr_i,
  pe3_pair_feeder_if.slave bus
);

  localparam int unsigned IdxW  = $clog2(2 * Stride);
  localparam int unsigned SlotW = IdxW - 1;

  logic [IdxW-1:0]      idx_q, idx_d;
  logic [DataWidth-1:0] buf_q [Stride];
  logic [DataWidth-1:0] u_q, u_d, v_q, v_d, rd_word;
  logic                 pair_valid_q, pair_valid_d;
  logic                 range_err_q, range_err_d;
  logic                 accept, pair_phase, last_pair;
  logic [SlotW-1:0]     slot;

  always_comb begin
    accept       = bus.in_valid & ~clr_i;
    pair_phase   = idx_q[IdxW-1];
    slot         = idx_q[SlotW-1:0];
    rd_word      = buf_q[slot];
    last_pair    = accept & (idx_q == {IdxW{1'b1}});

    idx_d        = idx_q;
    u_d          = u_q;
    v_d          = v_q;
    pair_valid_d = accept & pair_phase;
    range_err_d  = range_err_q;

    if (clr_i) begin
      idx_d       = '0;
      range_err_d = 1'b0;
    end else if (accept) begin
      idx_d = idx_q + 1'b1;
      if (bus.in_data >= DataWidth'(Modulus)) begin
        range_err_d = 1'b1;
      end
    end

    if (pair_valid_d) begin
      u_d = rd_word;
      v_d = bus.in_data;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      idx_q        <= '0;
      u_q          <= '0;
      v_q          <= '0;
      pair_valid_q <= 1'b0;
      range_err_q  <= 1'b0;
    end else begin
      idx_q        <= idx_d;
      u_q          <= u_d;
      v_q          <= v_d;
      pair_valid_q <= pair_valid_d;
      range_err_q  <= range_err_d;
    end
  end

  // Slot k is read in PAIR before the next block's FILL rewrites it, so one half-block suffices.
  always_ff @(posedge clk_i) begin
    if (accept && !pair_phase) begin
      buf_q[slot] <= bus.in_data;
    end
  end

  valid_delay #(
    .Depth (PeLat)
  ) u_res_dly (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .clr_i  (clr_i),
    .d_i    (pair_valid_q),
    .q_o    (bus.res_valid)
  );

  // Fed before the pair register, hence one stage deeper.
  valid_delay #(
    .Depth (PeLat + 1)
  ) u_blk_dly (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .clr_i  (clr_i),
    .d_i    (last_pair),
    .q_o    (bus.blk_done)
  );

  assign bus.u          = u_q;
  assign bus.v          = v_q;
  assign bus.pair_valid = pair_valid_q;
  assign bus.range_err  = range_err_q;

endmodule

// File: tb/tb_pe3_pair_feeder.sv
// Self-checking bench: pair/result scoreboard plus a table-driven range-check sequence.
module tb_pe3_pair_feeder;
  import pe3_pair_feeder_pkg::*;

  typedef struct packed {
    logic [11:0] u;
    logic [11:0] v;
  } pair_t;

  typedef struct packed {
    int unsigned due;
    logic        last;
  } res_t;

  typedef struct {
    logic        vld;
    logic        c;
    logic [11:0] d;
    logic        exp_pv;
    logic        exp_err;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic clr = 1'b0;

  always #5 clk = ~clk;

  pe3_pair_feeder_if bus ();

  pe3_pair_feeder dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .clr_i  (clr),
    .bus    (bus)
  );

  pair_t       pq[$];
  res_t        rq[$];
  int          n_chk = 0;
  int          n_fail = 0;
  int unsigned cyc = 0;
  int          m_idx = 0;
  logic [11:0] m_buf[8];
  logic        m_err = 1'b0;
  logic [11:0] last_u = '0;
  logic [11:0] last_v = '0;
  vec_t        tbl[18];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, want %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic check_cycle();
    pair_t p;
    res_t  r;
    if (bus.pair_valid) begin
      if (pq.size() == 0) begin
        chk("spurious_pair", 1, 0);
      end else begin
        p = pq.pop_front();
        chk("u", bus.u, p.u);
        chk("v", bus.v, p.v);
        last_u = p.u;
        last_v = p.v;
      end
    end else begin
      chk("pair_missing", pq.size(), 0);
      chk("u_hold", bus.u, last_u);
      chk("v_hold", bus.v, last_v);
      pq.delete();
    end
    if (rq.size() > 0 && rq[0].due == cyc) begin
      r = rq.pop_front();
      chk("res_valid", bus.res_valid, 1);
      chk("blk_done", bus.blk_done, r.last);
    end else begin
      chk("res_valid_idle", bus.res_valid, 0);
      chk("blk_done_idle", bus.blk_done, 0);
    end
    chk("range_err", bus.range_err, m_err);
  endtask

  // Drive one cycle, update the expectation model, then sample 1 time unit after the edge.
  task automatic step(input logic vld, input logic c, input logic [11:0] d);
    pair_t p;
    res_t  r;
    bus.in_valid = vld;
    bus.in_data  = d;
    clr          = c;
    cyc++;
    if (c) begin
      m_idx = 0;
      m_err = 1'b0;
      rq.delete();
    end else if (vld) begin
      if (d >= 12'd3329) m_err = 1'b1;
      if (m_idx < 8) begin
        m_buf[m_idx] = d;
      end else begin
        p.u = m_buf[m_idx-8];
        p.v = d;
        pq.push_back(p);
        r.due  = cyc + 6;
        r.last = (m_idx == 15);
        rq.push_back(r);
      end
      m_idx = (m_idx + 1) % 16;
    end
    @(posedge clk);
    #1;
    check_cycle();
  endtask

  task automatic do_reset();
    bus.in_valid = 1'b0;
    clr          = 1'b0;
    rst_n        = 1'b0;
    #1;
    chk("rst_u", bus.u, 0);
    chk("rst_v", bus.v, 0);
    chk("rst_pair_valid", bus.pair_valid, 0);
    chk("rst_res_valid", bus.res_valid, 0);
    chk("rst_blk_done", bus.blk_done, 0);
    chk("rst_range_err", bus.range_err, 0);
    m_idx  = 0;
    m_err  = 1'b0;
    last_u = '0;
    last_v = '0;
    pq.delete();
    rq.delete();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    step(1'b0, 1'b0, 12'd0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 12'd0);
  endtask

  initial begin
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    #1;
    do_reset();

    // Single block.
    for (int i = 0; i < 16; i++) step(1'b1, 1'b0, 12'(i));
    idle(8);

    // Back-to-back blocks.
    for (int i = 0; i < 32; i++) step(1'b1, 1'b0, 12'(100 + i));
    idle(8);

    // Bubbles every other cycle in PAIR.
    for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 12'(300 + i));
    for (int i = 8; i < 16; i++) begin
      step(1'b1, 1'b0, 12'(300 + i));
      step(1'b0, 1'b0, 12'hABC);
    end
    idle(8);

    // Range check, table-driven.
    for (int i = 0; i < 16; i++) begin
      tbl[i].vld     = 1'b1;
      tbl[i].c       = 1'b0;
      tbl[i].d       = (i == 3) ? 12'd3329 : 12'(i);
      tbl[i].exp_pv  = (i >= 8);
      tbl[i].exp_err = (i >= 3);
    end
    tbl[16] = '{vld: 1'b0, c: 1'b0, d: 12'd0, exp_pv: 1'b0, exp_err: 1'b1};
    tbl[17] = '{vld: 1'b1, c: 1'b1, d: 12'd5, exp_pv: 1'b0, exp_err: 1'b0};
    for (int i = 0; i < 18; i++) begin
      step(tbl[i].vld, tbl[i].c, tbl[i].d);
      chk("tbl_pair_valid", bus.pair_valid, tbl[i].exp_pv);
      chk("tbl_range_err", bus.range_err, tbl[i].exp_err);
    end
    idle(2);

    // Mid-operation reset at idx 11.
    for (int i = 0; i < 11; i++) step(1'b1, 1'b0, 12'(i));
    do_reset();
    for (int i = 0; i < 16; i++) step(1'b1, 1'b0, 12'(i));
    idle(8);

    // Clear with input at idx 5 while results are still in flight.
    for (int i = 0; i < 16; i++) step(1'b1, 1'b0, 12'(400 + i));
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 12'(500 + i));
    step(1'b1, 1'b1, 12'd777);
    for (int i = 0; i < 16; i++) step(1'b1, 1'b0, 12'(600 + i));
    idle(10);

    chk("pairs_drained", pq.size(), 0);
    chk("results_drained", rq.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
